comm_master: RTL and testbench
==============================

// Module: comm_master
// PURPOSE
//  Bench-side wireless-link master: serialises a command byte plus 16-bit data
//  word onto a UART line as three 8N1 frames and receives a single-byte response
//  frame back. Sits opposite the copter's UART command interface; TX drives the
//  copter RX, RX is driven by the copter TX.
// PARAMETERS
//  BAUD_DIV  2604  clk cycles per UART bit (50 MHz clk, 19200 baud)
// PORTS
//  clk           in   1   system clock, all logic on rising edge
//  rst_n         in   1   asynchronous active-low reset
//  RX            in   1   serial input from copter (asynchronous, idle high)
//  TX            out  1   serial output to copter (idle high)
//  cmd           in   8   command byte, captured on send_cmd
//  data          in   16  data word, captured on send_cmd
//  send_cmd      in   1   1-cycle pulse: start transmission of cmd,data
//  cmd_sent      out  1   high once all 3 frames sent; held until next send_cmd
//  resp          out  8   last received response byte
//  resp_rdy      out  1   high when resp holds a new byte
//  clr_resp_rdy  in   1   synchronous clear of resp_rdy
// BEHAVIOUR
//  Reset: TX=1, cmd_sent=0, resp_rdy=0, resp=8'h00, both FSMs idle.
//  Frame format: start bit 0, 8 data bits LSB first, stop bit 1; each bit
//   BAUD_DIV cycles; frame = 10*BAUD_DIV cycles.
//  TX sequencer FSM: IDLE -> SEND_HI -> SEND_MID -> SEND_LO -> IDLE.
//   IDLE: on send_cmd latch {cmd,data} into 24-bit shadow, clear cmd_sent,
//    go SEND_HI; TX frame starts next cycle.
//   SEND_HI sends cmd; SEND_MID sends data[15:8]; SEND_LO sends data[7:0].
//   Next frame starts the cycle after the previous stop bit ends (no idle gap).
//   After SEND_LO stop bit: cmd_sent<=1, return IDLE.
//   send_cmd while not IDLE is ignored; shadow is never overwritten mid-send.
//  Receiver: RX double-flop synchronised; falling edge in idle = start; sample
//   at BAUD_DIV/2 to verify start (if 1, false start, back to idle); then sample
//   each data bit at mid-bit, shift LSB first; sample stop bit at mid-bit.
//   At stop sample: resp<=shift reg, resp_rdy<=1 (byte delivered even if stop
//   bit is 0; no framing-error output).
//   resp_rdy cleared by clr_resp_rdy or by detection of a new start bit; if a
//   byte completes in the same cycle as clr_resp_rdy, set wins.
//  Transmitter and receiver independent; full-duplex operation allowed.
//  Reset mid-frame aborts immediately: TX returns high, partial RX byte dropped.
// STRUCTURE
//  Shared package: BAUD_DIV default, frame length constant, TX FSM state enum.
//  Sub-module uart_core (8N1 tx: trmt/tx_data/tx_done; rx: rdy/rx_data/clr_rdy,
//   both parameterised by BAUD_DIV); comm_master holds the 3-byte sequencer and
//   cmd_sent/resp_rdy logic.
// TESTING
//  1. Reset -> TX=1, cmd_sent=0, resp_rdy=0, resp=00 for 100 cycles.
//  2. cmd=08,data=0420,send_cmd pulse -> TX shows frames 08,04,20 back-to-back;
//     cmd_sent rises 30*2604=78120 cycles after start bit, stays high.
//  3. Second send_cmd (cmd=06,data=F0F0) -> cmd_sent drops next cycle, frames
//     06,F0,F0, cmd_sent rises again; send_cmd pulsed mid-send has no effect.
//  4. Drive RX with frame A5 -> resp=A5, resp_rdy=1 at stop-bit midpoint;
//     clr_resp_rdy pulse -> resp_rdy=0, resp stays A5.
//  5. RX glitch low for 100 cycles -> rejected as false start, resp_rdy stays 0.
//  6. Loop TX to RX, send 08/0420 -> resp_rdy pulses thrice, final resp=20;
//     assert rst_n mid-frame -> TX=1 and all outputs at reset values at once.

Source files
------------

// File: rtl/comm_master_pkg.sv
// Shared constants and state types for the comm_master UART link master.
// Used by the top-level sequencer and by the uart_core serialiser/deserialiser.
package comm_master_pkg;

  localparam int BAUD_DIV_DEFAULT = 2604;
  localparam int FRAME_BITS       = 10;
  localparam int FRAME_CYCLES     = FRAME_BITS * BAUD_DIV_DEFAULT;
  localparam int CNT_W            = 16;

  typedef enum logic [1:0] {
    TX_IDLE     = 2'd0,
    TX_SEND_HI  = 2'd1,
    TX_SEND_MID = 2'd2,
    TX_SEND_LO  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/comm_master_uart.sv
// 8N1 UART core: independent transmitter and receiver sharing one baud divisor.
// Handshake: trmt is a 1-cycle request accepted when idle or when tx_done is high
// (back-to-back frames); rdy is a sticky flag set on each received byte.
module uart_core
  import comm_master_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_done,
  input  logic       rx,
  input  logic       clr_rdy,
  output logic       rdy,
  output logic [7:0] rx_data,
  output logic [1:0] rx_state_dbg
);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // ---------------- transmitter ----------------
  logic [9:0]       tx_shift;
  logic [CNT_W-1:0] tx_baud;
  logic [3:0]       tx_bits;
  logic             tx_busy;
  logic             tx_tick;

  assign tx_tick = tx_busy && (tx_baud == BAUD_LAST);
  assign tx_done = tx_tick && (tx_bits == 4'd9);

  // Idle shifter holds all ones, so the line idles high with no extra mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '1;
      tx_baud  <= '0;
      tx_bits  <= '0;
      tx_busy  <= 1'b0;
    end else if (trmt && (!tx_busy || tx_done)) begin
      tx_shift <= {1'b1, tx_data, 1'b0};
      tx_baud  <= '0;
      tx_bits  <= '0;
      tx_busy  <= 1'b1;
    end else if (tx_busy) begin
      if (tx_tick) begin
        tx_baud  <= '0;
        tx_shift <= {1'b1, tx_shift[9:1]};
        tx_bits  <= tx_bits + 4'd1;
        if (tx_done) tx_busy <= 1'b0;
      end else begin
        tx_baud <= tx_baud + CNT_ONE;
      end
    end
  end

  assign tx = tx_shift[0];

  // ---------------- receiver ----------------
  logic             rx_ff1, rx_ff2, rx_ff3;
  logic             rx_fall;
  rx_state_t        rx_state, rx_next;
  logic [CNT_W-1:0] rx_baud;
  logic [2:0]       rx_bits;
  logic [7:0]       rx_shift;
  logic             rx_start_det;
  logic             rx_data_smp;
  logic             rx_stop_smp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1 <= 1'b1;
      rx_ff2 <= 1'b1;
      rx_ff3 <= 1'b1;
    end else begin
      rx_ff1 <= rx;
      rx_ff2 <= rx_ff1;
      rx_ff3 <= rx_ff2;
    end
  end

  assign rx_fall = !rx_ff2 && rx_ff3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      // A line found high at half-bit is treated as a glitch, not a start.
      RX_START: if (rx_baud == HALF_LAST) rx_next = rx_ff2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if ((rx_baud == BAUD_LAST) && (rx_bits == 3'd7)) rx_next = RX_STOP;
      RX_STOP:  if (rx_baud == BAUD_LAST) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_start_det = (rx_state == RX_IDLE) && rx_fall;
    rx_data_smp  = (rx_state == RX_DATA) && (rx_baud == BAUD_LAST);
    rx_stop_smp  = (rx_state == RX_STOP) && (rx_baud == BAUD_LAST);
  end

  // Counter restarts on every state change, so after the half-bit start check
  // each full-period count lands on the middle of the next bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_baud  <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
    end else begin
      if ((rx_state == RX_IDLE) || (rx_next != rx_state) || (rx_baud == BAUD_LAST))
        rx_baud <= '0;
      else
        rx_baud <= rx_baud + CNT_ONE;
      if (rx_state == RX_IDLE) rx_bits <= '0;
      else if (rx_data_smp)    rx_bits <= rx_bits + 3'd1;
      if (rx_data_smp) rx_shift <= {rx_ff2, rx_shift[7:1]};
    end
  end

  // Byte is delivered regardless of the stop-bit level; set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy     <= 1'b0;
      rx_data <= 8'h00;
    end else if (rx_stop_smp) begin
      rdy     <= 1'b1;
      rx_data <= rx_shift;
    end else if (clr_rdy || rx_start_det) begin
      rdy <= 1'b0;
    end
  end

  assign rx_state_dbg = rx_state;

endmodule

// File: rtl/comm_master.sv
// Bench-side link master: sends {cmd, data[15:8], data[7:0]} as three back-to-back
// 8N1 frames and collects single-byte responses. send_cmd is honoured only when idle.
module comm_master
  import comm_master_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        send_cmd,
  output logic        cmd_sent,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy,
  output logic [1:0]  tx_state_dbg,
  output logic [1:0]  rx_state_dbg
);

  tx_state_t   state, next;
  logic [23:0] shadow;
  logic        trmt;
  logic [7:0]  tx_byte;
  logic        tx_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= TX_IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      TX_IDLE:     if (send_cmd) next = TX_SEND_HI;
      TX_SEND_HI:  if (tx_done)  next = TX_SEND_MID;
      TX_SEND_MID: if (tx_done)  next = TX_SEND_LO;
      TX_SEND_LO:  if (tx_done)  next = TX_IDLE;
      default:     next = TX_IDLE;
    endcase
  end

  // The first frame is launched straight from the inputs so it starts on the
  // cycle after send_cmd; later frames chain off tx_done with no idle gap.
  always_comb begin
    trmt    = 1'b0;
    tx_byte = shadow[23:16];
    unique case (state)
      TX_IDLE: begin
        trmt    = send_cmd;
        tx_byte = cmd;
      end
      TX_SEND_HI: begin
        trmt    = tx_done;
        tx_byte = shadow[15:8];
      end
      TX_SEND_MID: begin
        trmt    = tx_done;
        tx_byte = shadow[7:0];
      end
      default: begin
        trmt    = 1'b0;
        tx_byte = shadow[23:16];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow   <= '0;
      cmd_sent <= 1'b0;
    end else if ((state == TX_IDLE) && send_cmd) begin
      shadow   <= {cmd, data};
      cmd_sent <= 1'b0;
    end else if ((state == TX_SEND_LO) && tx_done) begin
      cmd_sent <= 1'b1;
    end
  end

  uart_core #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart (
    .clk         (clk),
    .rst_n       (rst_n),
    .trmt        (trmt),
    .tx_data     (tx_byte),
    .tx          (TX),
    .tx_done     (tx_done),
    .rx          (RX),
    .clr_rdy     (clr_resp_rdy),
    .rdy         (resp_rdy),
    .rx_data     (resp),
    .rx_state_dbg(rx_state_dbg)
  );

  assign tx_state_dbg = state;

endmodule

// File: tb/tb_comm_master.sv
// Self-checking bench for comm_master with a shortened baud divisor.
// Frames on TX are decoded by mid-bit sampling; RX frames are synthesised bit by bit.
module tb_comm_master;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;
  logic        rx_line;
  logic        TX;
  logic [7:0]  cmd = 8'h00;
  logic [15:0] data = 16'h0000;
  logic        send_cmd = 1'b0;
  logic        cmd_sent;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        clr_resp_rdy = 1'b0;
  logic [1:0]  tx_state_dbg;
  logic [1:0]  rx_state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] data;
    logic [7:0]  e0;
    logic [7:0]  e1;
    logic [7:0]  e2;
  } vec_t;
  vec_t vecs[4];

  assign rx_line = loop_en ? TX : rx_drv;

  comm_master #(.BAUD_DIV(BD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (rx_line),
    .TX          (TX),
    .cmd         (cmd),
    .data        (data),
    .send_cmd    (send_cmd),
    .cmd_sent    (cmd_sent),
    .resp        (resp),
    .resp_rdy    (resp_rdy),
    .clr_resp_rdy(clr_resp_rdy),
    .tx_state_dbg(tx_state_dbg),
    .rx_state_dbg(rx_state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running after 100000 cycles");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_send(input logic [7:0] c, input logic [15:0] d);
    @(negedge clk);
    cmd = c;
    data = d;
    send_cmd = 1'b1;
    @(negedge clk);
    send_cmd = 1'b0;
  endtask

  // Decodes three frames from TX starting now, and checks cmd_sent timing.
  task automatic decode_check(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    logic [7:0]  b;
    logic [23:0] ex;
    int waited;
    ex = {e0, e1, e2};
    waited = 0;
    while (TX !== 1'b0 && waited < 4 * BD) begin
      @(negedge clk);
      waited++;
    end
    chk("tx_start_latency", 32'(waited), 32'd0);
    if (waited < 4 * BD) begin
      chk("cmd_sent_cleared", 32'(cmd_sent), 32'd0);
      b = 8'h00;
      repeat (BD / 2) @(negedge clk);
      for (int f = 0; f < 3; f++) begin
        chk("start_bit", 32'(TX), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          b[i] = TX;
        end
        repeat (BD) @(negedge clk);
        chk("stop_bit", 32'(TX), 32'd1);
        chk("tx_byte", 32'(b), 32'(ex[23 - 8 * f -: 8]));
        if (f < 2) repeat (BD) @(negedge clk);
      end
      repeat (BD / 2 - 1) @(negedge clk);
      chk("cmd_sent_early", 32'(cmd_sent), 32'd0);
      @(negedge clk);
      chk("cmd_sent_rise", 32'(cmd_sent), 32'd1);
      repeat (20) @(negedge clk);
      chk("cmd_sent_held", 32'(cmd_sent), 32'd1);
      chk("tx_idle_high", 32'(TX), 32'd1);
    end
  endtask

  // Drives one RX frame; optionally pulses clr_resp_rdy at offset clr_at.
  // rise_at is the offset at which resp_rdy is first seen rising.
  task automatic drive_rx(input logic [7:0] b, input logic stop, input int clr_at,
                          output int rise_at);
    logic [9:0] fr;
    logic seen_low;
    fr = {stop, b, 1'b0};
    rise_at = -1;
    seen_low = (resp_rdy !== 1'b1);
    for (int k = 0; k < 10 * BD; k++) begin
      @(negedge clk);
      if (resp_rdy !== 1'b1) seen_low = 1'b1;
      else if (seen_low && rise_at < 0) rise_at = k;
      rx_drv = fr[k / BD];
      clr_resp_rdy = (k == clr_at);
    end
    @(negedge clk);
    clr_resp_rdy = 1'b0;
    rx_drv = 1'b1;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_resp_rdy = 1'b1;
    @(negedge clk);
    clr_resp_rdy = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_tx"}, 32'(TX), 32'd1);
    chk({tag, "_cmd_sent"}, 32'(cmd_sent), 32'd0);
    chk({tag, "_resp_rdy"}, 32'(resp_rdy), 32'd0);
    chk({tag, "_resp"}, 32'(resp), 32'h00);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r, r_ref, rises;
    logic prev;
    logic [7:0] c8, rb, got;
    logic [15:0] d16;
    logic stop_b;

    vecs[0] = '{8'h08, 16'h0420, 8'h08, 8'h04, 8'h20};
    vecs[1] = '{8'h06, 16'hF0F0, 8'h06, 8'hF0, 8'hF0};
    vecs[2] = '{8'h00, 16'h0000, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{8'hFF, 16'hFFFF, 8'hFF, 8'hFF, 8'hFF};

    // Reset held, then 100 idle cycles at reset values.
    repeat (5) begin
      @(negedge clk);
      check_reset_values("in_reset");
    end
    rst_n = 1'b1;
    repeat (100) begin
      @(negedge clk);
      check_reset_values("post_reset");
    end

    // Table-driven transmit vectors.
    for (int v = 0; v < 4; v++) begin
      do_send(vecs[v].cmd, vecs[v].data);
      decode_check(vecs[v].e0, vecs[v].e1, vecs[v].e2);
    end

    // send_cmd mid-send must not disturb the frames in flight.
    do_send(8'h06, 16'hF0F0);
    fork
      decode_check(8'h06, 8'hF0, 8'hF0);
      begin
        repeat (12 * BD) @(negedge clk);
        cmd = 8'hAA;
        data = 16'h5555;
        send_cmd = 1'b1;
        @(negedge clk);
        send_cmd = 1'b0;
      end
    join

    // Randomised transmit; model splits the word into its three wire bytes.
    for (int n = 0; n < 4; n++) begin
      c8  = 8'($urandom_range(0, 255));
      d16 = 16'($urandom_range(0, 65535));
      do_send(c8, d16);
      decode_check(c8, d16[15:8], d16[7:0]);
    end

    // Receive A5, then clear.
    drive_rx(8'hA5, 1'b1, -1, r_ref);
    chk("rx_rise_in_window", 32'((r_ref >= 9 * BD + BD / 4) && (r_ref < 10 * BD)), 32'd1);
    chk("rx_rdy_a5", 32'(resp_rdy), 32'd1);
    chk("rx_resp_a5", 32'(resp), 32'hA5);
    repeat (5) @(negedge clk);
    pulse_clr();
    @(negedge clk);
    chk("rx_rdy_cleared", 32'(resp_rdy), 32'd0);
    chk("rx_resp_kept", 32'(resp), 32'hA5);

    // Short glitch is a false start.
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (BD / 4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (12 * BD) @(negedge clk);
    chk("glitch_rdy", 32'(resp_rdy), 32'd0);
    chk("glitch_resp", 32'(resp), 32'hA5);

    // Receiver recovers; then a new start bit clears a pending resp_rdy.
    drive_rx(8'h3C, 1'b1, -1, r);
    chk("rx_rise_3c", 32'(r), 32'(r_ref));
    chk("rx_resp_3c", 32'(resp), 32'h3C);
    drive_rx(8'h5A, 1'b1, -1, r);
    chk("rx_restart_clears", 32'(r), 32'(r_ref));
    chk("rx_resp_5a", 32'(resp), 32'h5A);

    // clr_resp_rdy in the completing cycle: set wins.
    drive_rx(8'h96, 1'b1, r_ref - 1, r);
    chk("set_wins_rdy", 32'(resp_rdy), 32'd1);
    chk("set_wins_resp", 32'(resp), 32'h96);
    // clr one cycle later: cleared.
    drive_rx(8'h69, 1'b1, r_ref + 1, r);
    chk("late_clr_rdy", 32'(resp_rdy), 32'd0);
    chk("late_clr_resp", 32'(resp), 32'h69);

    // Randomised receive, stop bit random (byte delivered either way).
    for (int n = 0; n < 6; n++) begin
      rb = 8'($urandom_range(0, 255));
      stop_b = 1'($urandom_range(0, 1));
      exp_q.push_back(rb);
      drive_rx(rb, stop_b, -1, r);
      got = exp_q.pop_front();
      chk("rand_rx_resp", 32'(resp), 32'(got));
      chk("rand_rx_rdy", 32'(resp_rdy), 32'd1);
      if ($urandom_range(0, 1) == 1) pulse_clr();
    end

    // Loopback: every transmitted byte comes back on resp.
    loop_en = 1'b1;
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h20);
    rises = 0;
    prev = resp_rdy;
    do_send(8'h08, 16'h0420);
    for (int k = 0; k < 32 * BD; k++) begin
      @(negedge clk);
      if (resp_rdy === 1'b1 && prev !== 1'b1) begin
        rises++;
        if (exp_q.size() > 0) begin
          got = exp_q.pop_front();
          chk("loop_byte", 32'(resp), 32'(got));
        end
      end
      prev = resp_rdy;
    end
    chk("loop_rises", 32'(rises), 32'd3);
    chk("loop_final_resp", 32'(resp), 32'h20);
    chk("loop_cmd_sent", 32'(cmd_sent), 32'd1);
    exp_q.delete();

    // Reset mid-frame while both directions are busy.
    do_send(8'h11, 16'h2233);
    repeat (5 * BD + 3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    chk("mid_reset_tx_state", 32'(tx_state_dbg), 32'd0);
    chk("mid_reset_rx_state", 32'(rx_state_dbg), 32'd0);
    repeat (3) @(negedge clk);
    loop_en = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_values("after_reset");

    // Both directions work cleanly after the abort.
    drive_rx(8'h7E, 1'b1, -1, r);
    chk("post_reset_rx_rise", 32'(r), 32'(r_ref));
    chk("post_reset_rx_resp", 32'(resp), 32'h7E);
    do_send(vecs[0].cmd, vecs[0].data);
    decode_check(vecs[0].e0, vecs[0].e1, vecs[0].e2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
